decode: RTL and testbench
=========================

# decode

Instruction-decode stage of the five-stage pipelined MIPS core, directly downstream of `fetch`. Consumes `Pc_IF`/`FetchData_IF`, reads the 32×32 register file, and resolves J/JAL in ID. Returns `Jump_IDM1`/`JumpTgt_IDM1`/`AnyStall` to `fetch` and registers decoded operands and controls into the ID/EX pipeline register. Owns load-use hazard detection.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; next edge loads a bubble into ID/EX.
- `Pc_IF` in 32: PC of the instruction in ID.
- `FetchData_IF` in 32: instruction word in ID.
- `BranchTaken_EXM1` in 1: EX branch taken; ID instruction is wrong-path.
- `RegWrite_WB` in 1, `WriteReg_WB` in 5, `WriteData_WB` in 32: write-back port.
- `Jump_IDM1` out 1, `JumpTgt_IDM1` out 26: J/JAL redirect to `fetch` (combinational).
- `AnyStall` out 1: hold fetch/ID (combinational).
- ID/EX register outputs:
  - `Valid_EX` 1; `Pc_EX` 32.
  - `RsData_EX` 32, `RtData_EX` 32, `Imm_EX` 32.
  - `Rs_EX` 5, `Rt_EX` 5, `WriteReg_EX` 5.
  - `AluOp_EX` 4, `AluSrc_EX` 1.
  - `RegWrite_EX` 1, `MemRead_EX` 1, `MemWrite_EX` 1, `MemToReg_EX` 1.
  - `Branch_EX` 2 (00 none, 01 beq, 10 bne).

## Operation
- **Supported instructions:**
  - R-type: add, sub, and, or, slt, sll, srl.
  - I-type: addi, andi, ori, slti, lui, lw, sw, beq, bne.
  - J-type: j, jal.
  - Any other encoding, including 0x00000000, decodes as a bubble (all controls 0, `Valid_EX`=0).
- **Immediates:**
  - Sign-extended: addi, slti, lw, sw, beq, bne.
  - Zero-extended: andi, ori.
  - lui: `{imm,16'h0}`, AluOp PASSB.
  - sll/srl: `Imm_EX` = zero-extended shamt; shift operates on rt.
- **Destination register:** rd for R-type, rt for I-type ALU and lw, 31 for jal. If the destination is 0, `RegWrite_EX` is forced to 0.
- **jal:** `Imm_EX`=`Pc_IF+4`, `AluSrc_EX`=1, AluOp PASSB, `RegWrite_EX`=1.
- **j/jal:** `Jump_IDM1`=1, `JumpTgt_IDM1`=instr[25:0]. Fetch forms the target; no delay slot; no bubble.
- **Register file:**
  - Write at posedge when `RegWrite_WB` and `WriteReg_WB`≠0.
  - Combinational reads; r0 always reads 0.
- **Source use:**
  - rs used by all except sll, srl, lui, j, jal.
  - rt used by R-type, sw, beq, bne.
- **Load-use stall:** when `Valid_EX & MemRead_EX & WriteReg_EX≠0`, and `WriteReg_EX` equals a used source:
  - `AnyStall`=1, `Jump_IDM1`=0.
  - ID/EX loads a bubble; ID instruction is held.
- **`BranchTaken_EXM1`:** forces `AnyStall`=0 and `Jump_IDM1`=0; ID/EX loads a bubble. Branch redirect always wins.
- **ID/EX load priority:** `flush` > `BranchTaken_EXM1` > `AnyStall` (all load a bubble) > decoded instruction.

## Timing
- Decode, hazard, and jump outputs are combinational on `FetchData_IF`. ID/EX latency is 1 cycle.
- A load followed immediately by a dependent instruction costs exactly 1 stall cycle. The next cycle the load is in MEM, so no further stall.
- **Reset (async, `rst_n`=0):**
  - All ID/EX outputs are 0, including `Valid_EX`=0.
  - All 32 registers are cleared to 0.
  - `AnyStall`/`Jump_IDM1` follow the current decode.
- Reset mid-stall: the stall clears because `Valid_EX`=0.
- A register write and a same-cycle read of the same register are governed by the configuration below.

## Configuration
- **`DECODE_WB_BYPASS_EN` defined:** a same-cycle WB write to a non-zero used source is forwarded, so `RsData`/`RtData` take `WriteData_WB`; no stall.
- **Undefined:** that condition additionally asserts `AnyStall` for 1 cycle. The next cycle reads the written value. `BranchTaken_EXM1` still overrides.

## Structure
- **`decode_pkg`:**
  - Opcode/funct constants.
  - AluOp encoding: ADD 0, SUB 1, AND 2, OR 3, SLT 4, SLL 5, SRL 6, PASSB 7.
  - Branch encoding.
  - Bubble control-struct constant.
- **Sub-module `regfile`:** 32×32, 2 read / 1 write, async active-low clear, r0 hardwired.
- Hazard and decode logic stay inline in `decode`.

## Test plan
1. Reset, then `addi r1,r0,5` (0x20010005): `Valid_EX`=1, `Imm_EX`=5, `WriteReg_EX`=1, `RegWrite_EX`=1, AluOp ADD.
2. `lw r2,0(r1)` then `add r3,r2,r1`:
   - Second cycle: `AnyStall`=1 for exactly 1 cycle and a bubble enters EX.
   - Then `add` issues with `Rs_EX`=2.
3. `jal 0x0000040` at `Pc_IF`=0x100:
   - `Jump_IDM1`=1, `JumpTgt_IDM1`=0x40.
   - Next cycle `Imm_EX`=0x104, `WriteReg_EX`=31.
4. WB writes r4=0xDEADBEEF while ID reads r4:
   - With the macro: `RsData_EX`=0xDEADBEEF, no stall.
   - Without: 1-cycle stall, then 0xDEADBEEF.
5. Load-use stall coincident with `BranchTaken_EXM1`=1: `AnyStall`=0, bubble enters ID/EX. Also `add r0,r1,r1`: `RegWrite_EX`=0.
6. `flush` or `rst_n` low during a pending stall:
   - Next edge gives `Valid_EX`=0.
   - 0x00000000 in ID gives a bubble with `Valid_EX`=0.

Source files
------------

// File: rtl/decode_pkg.sv
// ============================================================================
// Module      : decode_pkg
// Description : Opcode/funct constants, ALU and branch encodings and the
//               decoded-control / ID-EX record types shared by the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_SLL = 6'h00;
    localparam logic [5:0] c_FN_SRL = 6'h02;
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        c_ALU_ADD   = 4'd0,
        c_ALU_SUB   = 4'd1,
        c_ALU_AND   = 4'd2,
        c_ALU_OR    = 4'd3,
        c_ALU_SLT   = 4'd4,
        c_ALU_SLL   = 4'd5,
        c_ALU_SRL   = 4'd6,
        c_ALU_PASSB = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        c_BR_NONE = 2'b00,
        c_BR_BEQ  = 2'b01,
        c_BR_BNE  = 2'b10
    } branch_e;

    typedef struct packed {
        logic    valid;
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        branch_e branch;
    } ctrl_t;

    localparam ctrl_t c_CTRL_BUBBLE = '{
        valid:      1'b0,
        alu_op:     c_ALU_ADD,
        alu_src:    1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     c_BR_NONE
    };

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
    } idex_t;

    localparam idex_t c_IDEX_BUBBLE = '{
        ctrl:    c_CTRL_BUBBLE,
        pc:      32'd0,
        rs_data: 32'd0,
        rt_data: 32'd0,
        imm:     32'd0,
        rs:      5'd0,
        rt:      5'd0,
        wreg:    5'd0
    };

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_regfile.sv
// ============================================================================
// Module      : regfile
// Description : 32x32 register file, two combinational read ports, one write
//               port, asynchronous active-low clear, r0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    wire [31:0] w_regs [32];

    for (genvar g = 0; g < 32; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign w_regs[g] = 32'd0;
        end else begin : g_store
            logic [31:0] data_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= 32'd0;
                end else if (we_i && (waddr_i == 5'(g))) begin
                    data_q <= wdata_i;
                end
            end
            assign w_regs[g] = data_q;
        end
    end

    assign rdata1_o = w_regs[raddr1_i];
    assign rdata2_o = w_regs[raddr2_i];

endmodule

`default_nettype wire

// File: rtl/decode.sv
// ============================================================================
// Module      : decode
// Description : MIPS ID stage: decode, register read, J/JAL redirect, load-use
//               hazard detection and the ID/EX pipeline register.
//               DECODE_WB_BYPASS_EN: forward same-cycle WB data instead of stalling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] Pc_IF,
    input  logic [31:0] FetchData_IF,
    input  logic        BranchTaken_EXM1,
    input  logic        RegWrite_WB,
    input  logic [4:0]  WriteReg_WB,
    input  logic [31:0] WriteData_WB,
    output logic        Jump_IDM1,
    output logic [25:0] JumpTgt_IDM1,
    output logic        AnyStall,
    output logic        Valid_EX,
    output logic [31:0] Pc_EX,
    output logic [31:0] RsData_EX,
    output logic [31:0] RtData_EX,
    output logic [31:0] Imm_EX,
    output logic [4:0]  Rs_EX,
    output logic [4:0]  Rt_EX,
    output logic [4:0]  WriteReg_EX,
    output logic [3:0]  AluOp_EX,
    output logic        AluSrc_EX,
    output logic        RegWrite_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        MemToReg_EX,
    output logic [1:0]  Branch_EX
);

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
    logic [15:0] w_imm16;

    assign w_op    = FetchData_IF[31:26];
    assign w_rs    = FetchData_IF[25:21];
    assign w_rt    = FetchData_IF[20:16];
    assign w_rd    = FetchData_IF[15:11];
    assign w_shamt = FetchData_IF[10:6];
    assign w_funct = FetchData_IF[5:0];
    assign w_imm16 = FetchData_IF[15:0];

    ctrl_t       w_ctrl;
    logic [31:0] w_imm;
    logic [4:0]  w_dest;
    logic        w_use_rs, w_use_rt, w_jump, w_shift;

    always_comb begin
        w_ctrl   = c_CTRL_BUBBLE;
        w_imm    = 32'd0;
        w_dest   = 5'd0;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_jump   = 1'b0;
        w_shift  = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                // all-zero word is the canonical nop and must not issue as sll
                w_ctrl.valid = (FetchData_IF != 32'd0);
                case (w_funct)
                    c_FN_ADD: w_ctrl.alu_op = c_ALU_ADD;
                    c_FN_SUB: w_ctrl.alu_op = c_ALU_SUB;
                    c_FN_AND: w_ctrl.alu_op = c_ALU_AND;
                    c_FN_OR:  w_ctrl.alu_op = c_ALU_OR;
                    c_FN_SLT: w_ctrl.alu_op = c_ALU_SLT;
                    c_FN_SLL: begin w_ctrl.alu_op = c_ALU_SLL; w_shift = 1'b1; end
                    c_FN_SRL: begin w_ctrl.alu_op = c_ALU_SRL; w_shift = 1'b1; end
                    default:  w_ctrl.valid = 1'b0;
                endcase
                w_ctrl.reg_write = 1'b1;
                w_dest   = w_rd;
                w_use_rs = ~w_shift;
                w_use_rt = 1'b1;
                w_imm    = w_shift ? {27'd0, w_shamt} : 32'd0;
            end
            c_OP_ADDI, c_OP_SLTI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: begin
                w_ctrl.valid     = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_dest   = w_rt;
                w_use_rs = 1'b1;
                w_imm    = sext16(w_imm16);
                case (w_op)
                    c_OP_SLTI: w_ctrl.alu_op = c_ALU_SLT;
                    c_OP_ANDI: begin w_ctrl.alu_op = c_ALU_AND; w_imm = {16'd0, w_imm16}; end
                    c_OP_ORI:  begin w_ctrl.alu_op = c_ALU_OR;  w_imm = {16'd0, w_imm16}; end
                    c_OP_LUI: begin
                        w_ctrl.alu_op = c_ALU_PASSB;
                        w_imm    = {w_imm16, 16'd0};
                        w_use_rs = 1'b0;
                    end
                    default:   w_ctrl.alu_op = c_ALU_ADD;
                endcase
            end
            c_OP_LW: begin
                w_ctrl.valid      = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_dest   = w_rt;
                w_use_rs = 1'b1;
                w_imm    = sext16(w_imm16);
            end
            c_OP_SW: begin
                w_ctrl.valid     = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_imm    = sext16(w_imm16);
            end
            c_OP_BEQ, c_OP_BNE: begin
                w_ctrl.valid  = 1'b1;
                w_ctrl.alu_op = c_ALU_SUB;
                w_ctrl.branch = (w_op == c_OP_BEQ) ? c_BR_BEQ : c_BR_BNE;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_imm    = sext16(w_imm16);
            end
            c_OP_J: begin
                w_ctrl.valid = 1'b1;
                w_jump       = 1'b1;
            end
            c_OP_JAL: begin
                w_ctrl.valid     = 1'b1;
                w_ctrl.alu_op    = c_ALU_PASSB;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_dest = 5'd31;
                w_imm  = Pc_IF + 32'd4;
                w_jump = 1'b1;
            end
            default: ;
        endcase
        if (!w_ctrl.valid) begin
            w_ctrl   = c_CTRL_BUBBLE;
            w_imm    = 32'd0;
            w_dest   = 5'd0;
            w_use_rs = 1'b0;
            w_use_rt = 1'b0;
            w_jump   = 1'b0;
        end
        if (w_dest == 5'd0) begin
            w_ctrl.reg_write = 1'b0;
        end
    end

    logic [31:0] w_rf_rs, w_rf_rt, w_rs_data, w_rt_data;

    regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (w_rs),
        .raddr2_i (w_rt),
        .rdata1_o (w_rf_rs),
        .rdata2_o (w_rf_rt),
        .we_i     (RegWrite_WB),
        .waddr_i  (WriteReg_WB),
        .wdata_i  (WriteData_WB)
    );

    idex_t idex_q, idex_d;
    logic  w_wb_rs, w_wb_rt, w_load_use, w_stall_raw;

    assign w_wb_rs = RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == w_rs);
    assign w_wb_rt = RegWrite_WB && (WriteReg_WB != 5'd0) && (WriteReg_WB == w_rt);

    assign w_load_use = idex_q.ctrl.valid && idex_q.ctrl.mem_read && (idex_q.wreg != 5'd0) &&
                        ((w_use_rs && (w_rs == idex_q.wreg)) || (w_use_rt && (w_rt == idex_q.wreg)));

`ifdef DECODE_WB_BYPASS_EN
    assign w_rs_data   = w_wb_rs ? WriteData_WB : w_rf_rs;
    assign w_rt_data   = w_wb_rt ? WriteData_WB : w_rf_rt;
    assign w_stall_raw = w_load_use;
`else
    assign w_rs_data   = w_rf_rs;
    assign w_rt_data   = w_rf_rt;
    // hold one cycle so the source is read after the WB write has landed
    assign w_stall_raw = w_load_use || (w_wb_rs && w_use_rs) || (w_wb_rt && w_use_rt);
`endif

    assign AnyStall     = w_stall_raw && !BranchTaken_EXM1;
    assign Jump_IDM1    = w_jump && !w_stall_raw && !BranchTaken_EXM1;
    assign JumpTgt_IDM1 = FetchData_IF[25:0];

    always_comb begin
        idex_d = c_IDEX_BUBBLE;
        if (!(flush || BranchTaken_EXM1 || w_stall_raw) && w_ctrl.valid) begin
            idex_d.ctrl    = w_ctrl;
            idex_d.pc      = Pc_IF;
            idex_d.rs_data = w_rs_data;
            idex_d.rt_data = w_rt_data;
            idex_d.imm     = w_imm;
            idex_d.rs      = w_rs;
            idex_d.rt      = w_rt;
            idex_d.wreg    = w_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= c_IDEX_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign Valid_EX    = idex_q.ctrl.valid;
    assign Pc_EX       = idex_q.pc;
    assign RsData_EX   = idex_q.rs_data;
    assign RtData_EX   = idex_q.rt_data;
    assign Imm_EX      = idex_q.imm;
    assign Rs_EX       = idex_q.rs;
    assign Rt_EX       = idex_q.rt;
    assign WriteReg_EX = idex_q.wreg;
    assign AluOp_EX    = idex_q.ctrl.alu_op;
    assign AluSrc_EX   = idex_q.ctrl.alu_src;
    assign RegWrite_EX = idex_q.ctrl.reg_write;
    assign MemRead_EX  = idex_q.ctrl.mem_read;
    assign MemWrite_EX = idex_q.ctrl.mem_write;
    assign MemToReg_EX = idex_q.ctrl.mem_to_reg;
    assign Branch_EX   = idex_q.ctrl.branch;

endmodule

`default_nettype wire

// File: tb/tb_decode.sv
// ============================================================================
// Module      : tb_decode
// Description : Table-driven directed bench for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] Pc_IF = 32'd0;
    logic [31:0] FetchData_IF = 32'd0;
    logic        BranchTaken_EXM1 = 1'b0;
    logic        RegWrite_WB = 1'b0;
    logic [4:0]  WriteReg_WB = 5'd0;
    logic [31:0] WriteData_WB = 32'd0;

    logic        Jump_IDM1, AnyStall, Valid_EX;
    logic [25:0] JumpTgt_IDM1;
    logic [31:0] Pc_EX, RsData_EX, RtData_EX, Imm_EX;
    logic [4:0]  Rs_EX, Rt_EX, WriteReg_EX;
    logic [3:0]  AluOp_EX;
    logic        AluSrc_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX;
    logic [1:0]  Branch_EX;

    decode dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .Pc_IF(Pc_IF), .FetchData_IF(FetchData_IF),
        .BranchTaken_EXM1(BranchTaken_EXM1), .RegWrite_WB(RegWrite_WB),
        .WriteReg_WB(WriteReg_WB), .WriteData_WB(WriteData_WB),
        .Jump_IDM1(Jump_IDM1), .JumpTgt_IDM1(JumpTgt_IDM1), .AnyStall(AnyStall),
        .Valid_EX(Valid_EX), .Pc_EX(Pc_EX), .RsData_EX(RsData_EX), .RtData_EX(RtData_EX),
        .Imm_EX(Imm_EX), .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .WriteReg_EX(WriteReg_EX),
        .AluOp_EX(AluOp_EX), .AluSrc_EX(AluSrc_EX), .RegWrite_EX(RegWrite_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .MemToReg_EX(MemToReg_EX),
        .Branch_EX(Branch_EX)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr, pc;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        br, fl;
        logic        e_stall, e_jump, e_valid;
        logic [31:0] e_imm;
        logic [4:0]  e_wreg;
        logic        e_rw;
        logic [3:0]  e_alu;
        logic [4:0]  e_rs;
        logic [31:0] e_rsdata;
        logic        e_mr;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t v(
        input logic [31:0] instr, pc, we, wreg, wdata, br, fl,
        input logic [31:0] e_stall, e_jump, e_valid, e_imm, e_wreg, e_rw, e_alu, e_rs, e_rsdata, e_mr);
        vec_t r;
        r.instr = instr;        r.pc = pc;
        r.we = we[0];           r.wreg = wreg[4:0];       r.wdata = wdata;
        r.br = br[0];           r.fl = fl[0];
        r.e_stall = e_stall[0]; r.e_jump = e_jump[0];     r.e_valid = e_valid[0];
        r.e_imm = e_imm;        r.e_wreg = e_wreg[4:0];   r.e_rw = e_rw[0];
        r.e_alu = e_alu[3:0];   r.e_rs = e_rs[4:0];       r.e_rsdata = e_rsdata;
        r.e_mr = e_mr[0];
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // entered just after a rising edge; leaves just after the next one
    task automatic run_vec(input vec_t t, input int idx);
        FetchData_IF     = t.instr;
        Pc_IF            = t.pc;
        RegWrite_WB      = t.we;
        WriteReg_WB      = t.wreg;
        WriteData_WB     = t.wdata;
        BranchTaken_EXM1 = t.br;
        flush            = t.fl;
        @(negedge clk);
        check("AnyStall", idx, 32'(AnyStall), 32'(t.e_stall));
        check("Jump_IDM1", idx, 32'(Jump_IDM1), 32'(t.e_jump));
        if (t.e_jump)
            check("JumpTgt_IDM1", idx, 32'(JumpTgt_IDM1), 32'(t.instr[25:0]));
        @(posedge clk);
        #1;
        check("Valid_EX", idx, 32'(Valid_EX), 32'(t.e_valid));
        check("Imm_EX", idx, Imm_EX, t.e_imm);
        check("WriteReg_EX", idx, 32'(WriteReg_EX), 32'(t.e_wreg));
        check("RegWrite_EX", idx, 32'(RegWrite_EX), 32'(t.e_rw));
        check("AluOp_EX", idx, 32'(AluOp_EX), 32'(t.e_alu));
        check("Rs_EX", idx, 32'(Rs_EX), 32'(t.e_rs));
        check("RsData_EX", idx, RsData_EX, t.e_rsdata);
        check("MemRead_EX", idx, 32'(MemRead_EX), 32'(t.e_mr));
        check("Pc_EX", idx, Pc_EX, t.e_valid ? t.pc : 32'd0);
    endtask

    vec_t tbl[20];

    initial begin
        //         instr         pc     we wr wdata         br fl  st jp va imm           wr rw alu rs rsdata        mr
        tbl[0]  = v(32'h20010005, 'h00, 0, 0, 0,            0, 0,  0, 0, 1, 5,            1, 1, 0,  0, 0,            0);
        tbl[1]  = v(32'h3405F000, 'h04, 1, 1, 5,            0, 0,  0, 0, 1, 'hF000,       5, 1, 3,  0, 0,            0);
        tbl[2]  = v(32'h8C220000, 'h08, 0, 0, 0,            0, 0,  0, 0, 1, 0,            2, 1, 0,  1, 5,            1);
        tbl[3]  = v(32'h00411820, 'h0C, 0, 0, 0,            0, 0,  1, 0, 0, 0,            0, 0, 0,  0, 0,            0);
        tbl[4]  = v(32'h00411820, 'h0C, 0, 0, 0,            0, 0,  0, 0, 1, 0,            3, 1, 0,  2, 0,            0);
        tbl[5]  = v(32'h0C000040, 'h100,0, 0, 0,            0, 0,  0, 1, 1, 'h104,        31,1, 7,  0, 0,            0);
`ifdef DECODE_WB_BYPASS_EN
        tbl[6]  = v(32'h20860001, 'h40, 1, 4, 32'hDEADBEEF, 0, 0,  0, 0, 1, 1,            6, 1, 0,  4, 32'hDEADBEEF, 0);
`else
        tbl[6]  = v(32'h20860001, 'h40, 1, 4, 32'hDEADBEEF, 0, 0,  1, 0, 0, 0,            0, 0, 0,  0, 0,            0);
`endif
        tbl[7]  = v(32'h20860001, 'h40, 0, 0, 0,            0, 0,  0, 0, 1, 1,            6, 1, 0,  4, 32'hDEADBEEF, 0);
        tbl[8]  = v(32'h8C870000, 'h44, 0, 0, 0,            0, 0,  0, 0, 1, 0,            7, 1, 0,  4, 32'hDEADBEEF, 1);
        tbl[9]  = v(32'hAC270004, 'h48, 0, 0, 0,            1, 0,  0, 0, 0, 0,            0, 0, 0,  0, 0,            0);
        tbl[10] = v(32'h00210020, 'h4C, 0, 0, 0,            0, 0,  0, 0, 1, 0,            0, 0, 0,  1, 5,            0);
        tbl[11] = v(32'h00000000, 'h50, 0, 0, 0,            0, 0,  0, 0, 0, 0,            0, 0, 0,  0, 0,            0);
        tbl[12] = v(32'h00214022, 'h54, 0, 0, 0,            0, 1,  0, 0, 0, 0,            0, 0, 0,  0, 0,            0);
        tbl[13] = v(32'h000148C0, 'h58, 0, 0, 0,            0, 0,  0, 0, 1, 3,            9, 1, 5,  0, 0,            0);
        tbl[14] = v(32'h282AFFFF, 'h5C, 0, 0, 0,            0, 0,  0, 0, 1, 32'hFFFFFFFF, 10,1, 4,  1, 5,            0);
        tbl[15] = v(32'h3C0B1234, 'h60, 0, 0, 0,            0, 0,  0, 0, 1, 32'h12340000, 11,1, 7,  0, 0,            0);
        tbl[16] = v(32'h8C220000, 'h64, 0, 0, 0,            0, 0,  0, 0, 1, 0,            2, 1, 0,  1, 5,            1);
        tbl[17] = v(32'h00411820, 'h68, 0, 0, 0,            0, 1,  1, 0, 0, 0,            0, 0, 0,  0, 0,            0);
        tbl[18] = v(32'h00411820, 'h68, 0, 0, 0,            0, 0,  0, 0, 1, 0,            3, 1, 0,  2, 0,            0);
        tbl[19] = v(32'h08123456, 'h6C, 0, 0, 0,            0, 0,  0, 1, 1, 0,            0, 0, 0,  0, 0,            0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_Valid_EX", 0, 32'(Valid_EX), 0);
        check("rst_Imm_EX", 0, Imm_EX, 0);
        check("rst_WriteReg_EX", 0, 32'(WriteReg_EX), 0);
        check("rst_AnyStall", 0, 32'(AnyStall), 0);
        check("rst_Jump_IDM1", 0, 32'(Jump_IDM1), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_vec(tbl[i], i);
        end

        // reset asserted while a load-use stall is pending, then registers read back cleared
        run_vec(v(32'h8C220000, 'h70, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1, 5, 1), 100);
        FetchData_IF = 32'h00411820;
        Pc_IF        = 32'h74;
        @(negedge clk);
        check("stall_before_rst", 101, 32'(AnyStall), 1);
        rst_n = 1'b0;
        #1;
        check("Valid_EX_in_rst", 101, 32'(Valid_EX), 0);
        check("MemRead_EX_in_rst", 101, 32'(MemRead_EX), 0);
        check("AnyStall_in_rst", 101, 32'(AnyStall), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(v(32'h202C0000, 'h78, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12, 1, 0, 1, 0, 0), 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
